ascii_cmd_parser: RTL

//  Sequential successor of the combinational ASCII->opcode converter. Consumes the UART RX

---
 rtl/ascii_cmd_parser.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ascii_cmd_parser.sv
// Byte-stream command parser: "<A><op><B>\r" -> {operand_a, operand_b, opcode} with valid/ready.
// Operands accumulate in decimal or lowercase hex; errors pulse err and hold err_code.
module ascii_cmd_parser #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OP_WIDTH   = 6,
    parameter int unsigned MAX_DIGITS = 3,
    parameter int unsigned HEX_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done_tick,
    input  logic                  cmd_ready,
    output logic                  cmd_valid,
    output logic [DATA_WIDTH-1:0] operand_a,
    output logic [DATA_WIDTH-1:0] operand_b,
    output logic [OP_WIDTH-1:0]   opcode,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic                  overrun
);

    localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);
    localparam int unsigned Base = (HEX_MODE != 0) ? 16 : 10;
    localparam logic [1:0] ErrBadChar  = 2'b01;
    localparam logic [1:0] ErrOverflow = 2'b10;
    localparam logic [1:0] ErrMissing  = 2'b11;

    typedef enum logic [2:0] {StIdle, StOpA, StOpB, StHold, StErr} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [OP_WIDTH-1:0]   opcode_q, opcode_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic                  overrun_q, overrun_d;

    logic                  is_digit, is_op, is_cr, is_space, cnt_full;
    logic [3:0]            digit_val;
    logic [5:0]            op_raw;
    logic [DATA_WIDTH-1:0] acc_sel, acc_mac;

    always_comb begin
        is_digit  = 1'b0;
        digit_val = 4'd0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_digit  = 1'b1;
            digit_val = rx_data[3:0];
        end else if (HEX_MODE != 0 && rx_data >= 8'h61 && rx_data <= 8'h66) begin
            is_digit  = 1'b1;
            digit_val = rx_data[3:0] + 4'd9;
        end
        is_op  = 1'b1;
        op_raw = 6'b000000;
        case (rx_data)
            8'h2B:   op_raw = 6'b100000;
            8'h2D:   op_raw = 6'b100010;
            8'h41:   op_raw = 6'b100100;
            8'h4F:   op_raw = 6'b100101;
            8'h58:   op_raw = 6'b100110;
            8'h4E:   op_raw = 6'b100111;
            8'h3E:   op_raw = 6'b000011;
            8'h2F:   op_raw = 6'b000010;
            default: is_op  = 1'b0;
        endcase
    end

    assign is_cr    = (rx_data == 8'h0D);
    assign is_space = (rx_data == 8'h20);
    assign cnt_full = (cnt_q == CntW'(MAX_DIGITS));
    assign acc_sel  = (state_q == StOpB) ? acc_b_q : acc_a_q;
    assign acc_mac  = DATA_WIDTH'(acc_sel * DATA_WIDTH'(Base) + DATA_WIDTH'(digit_val));

    always_comb begin
        state_d    = state_q;
        acc_a_d    = acc_a_q;
        acc_b_d    = acc_b_q;
        cnt_d      = cnt_q;
        opcode_d   = opcode_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        overrun_d  = 1'b0;
        unique case (state_q)
            StIdle: if (rx_done_tick && !is_cr && !is_space) begin
                if (is_digit) begin
                    acc_a_d = DATA_WIDTH'(digit_val);
                    cnt_d   = CntW'(1);
                    state_d = StOpA;
                end else begin
                    state_d = StErr; err_d = 1'b1; err_code_d = ErrBadChar;
                end
            end
            StOpA, StOpB: if (rx_done_tick && !is_space) begin
                if (is_digit) begin
                    if (cnt_full) begin
                        state_d = StErr; err_d = 1'b1; err_code_d = ErrOverflow;
                    end else begin
                        if (state_q == StOpA) acc_a_d = acc_mac;
                        else                  acc_b_d = acc_mac;
                        cnt_d = cnt_q + CntW'(1);
                    end
                end else if (is_cr) begin
                    // The CR that reveals a missing operand also ends the line, so skip ERR.
                    if (state_q == StOpB && cnt_q != '0) begin
                        state_d = StHold;
                    end else begin
                        state_d = StIdle; err_d = 1'b1; err_code_d = ErrMissing;
                    end
                end else if (is_op && state_q == StOpA) begin
                    opcode_d = OP_WIDTH'(op_raw);
                    acc_b_d  = '0;
                    cnt_d    = '0;
                    state_d  = StOpB;
                end else begin
                    state_d = StErr; err_d = 1'b1; err_code_d = ErrBadChar;
                end
            end
            StHold: begin
                overrun_d = rx_done_tick;
                if (cmd_ready) state_d = StIdle;
            end
            StErr: if (rx_done_tick && is_cr) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            acc_a_q    <= '0;
            acc_b_q    <= '0;
            cnt_q      <= '0;
            opcode_q   <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_a_q    <= acc_a_d;
            acc_b_q    <= acc_b_d;
            cnt_q      <= cnt_d;
            opcode_q   <= opcode_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            overrun_q  <= overrun_d;
        end
    end

    assign cmd_valid = (state_q == StHold);
    assign operand_a = acc_a_q;
    assign operand_b = acc_b_q;
    assign opcode    = opcode_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign overrun   = overrun_q;

endmodule
